pipeline_interlock: RTL and testbench

Stall and flush controller for the 5-stage pipeline. It consumes the load-use stall from the data-hazard detector, the branch-taken redirect from X, and the multdiv ready handshake. It produces the per-latch write enables and bubble/flush controls for PC, F/D, D/X, X/M and M/W, and it launches and tracks multi-cycle mul/div operations. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/md_watchdog.sv | 35 +++
 rtl/pipeline_interlock.sv | 152 +++++++++++++++
 tb/tb_pipeline_interlock.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control slice.
// Holds the opcode / ALU-op field constants, the interlock FSM state
// encoding and a small decode helper for multi-cycle mul/div instructions.
package pipe_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  // Returns {is_mul, is_div} for an instruction word. Only ALU-format
  // instructions (opcode 00000) carry an ALU-op field in bits [6:2].
  function automatic logic [1:0] md_decode(input logic [31:0] insn);
    logic alu_fmt;
    alu_fmt = (insn[31:27] == OP_ALU);
    return {alu_fmt && (insn[6:2] == ALU_MUL),
            alu_fmt && (insn[6:2] == ALU_DIV)};
  endfunction

endpackage

// File: rtl/md_watchdog.sv
// Cycle watchdog for outstanding mul/div operations.
// Ports:
//   clock, reset : pipeline clock, asynchronous active-high reset
//   clr          : synchronous clear to 0 (takes priority over en)
//   en           : count one cycle
//   expired      : count has reached MD_TIMEOUT-1
module md_watchdog #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Count never exceeds MD_TIMEOUT-1, so clog2 bits suffice; keep at
  // least one bit for degenerate timeouts.
  localparam int W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

  logic [W-1:0] count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == W'(MD_TIMEOUT - 1));

endmodule

// File: rtl/pipeline_interlock.sv
// Stall / flush controller for the 5-stage pipeline.
// Combines load-use stalls, X-stage branch redirects and the multdiv
// handshake into per-latch write enables and bubble/flush controls,
// launches mul/div operations and tracks them until the result (or an
// exception, or the watchdog) releases the pipeline.
// Ports:
//   clock, reset           : clock, asynchronous active-high reset
//   load_use, branch_taken : hazard inputs (same-cycle)
//   dx_insn                : instruction in the D/X latch
//   md_rdy, md_exc         : multdiv completion (exception counts as done)
//   pc_we..mw_we           : latch write enables
//   fd_flush, dx_bubble,
//   xm_bubble              : nop-insertion controls
//   ctrl_mult, ctrl_div    : one-cycle multdiv start pulses
//   md_busy                : waiting on multdiv
//   md_timeout             : sticky watchdog-expiry flag
//   stall_count            : saturating count of cycles with pc_we low
module pipeline_interlock
  import pipe_pkg::*;
#(
  parameter int MD_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic [31:0] dx_insn,
  input  logic        md_rdy,
  input  logic        md_exc,
  output logic        pc_we,
  output logic        fd_we,
  output logic        dx_we,
  output logic        xm_we,
  output logic        mw_we,
  output logic        fd_flush,
  output logic        dx_bubble,
  output logic        xm_bubble,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        md_busy,
  output logic        md_timeout,
  output logic [31:0] stall_count
);

  state_t      state_reg, state_next;
  logic [1:0]  md_kind;
  logic        wd_clr, wd_en, wd_expired;
  logic        set_timeout;
  logic        md_timeout_reg;
  logic [31:0] stall_count_reg;

  assign md_kind = md_decode(dx_insn);

  md_watchdog #(.MD_TIMEOUT(MD_TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // All controls are forced low while reset is held so nothing launches
  // or advances until the pipeline is out of reset.
  always_comb begin
    state_next  = state_reg;
    pc_we       = 1'b0;
    fd_we       = 1'b0;
    dx_we       = 1'b0;
    xm_we       = 1'b0;
    mw_we       = 1'b0;
    fd_flush    = 1'b0;
    dx_bubble   = 1'b0;
    xm_bubble   = 1'b0;
    ctrl_mult   = 1'b0;
    ctrl_div    = 1'b0;
    md_busy     = 1'b0;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
    set_timeout = 1'b0;
    if (!reset) begin
      unique case (state_reg)
        RUN: begin
          wd_clr = 1'b1;
          if (|md_kind) begin
            // Launch: hold the mul/div in D/X, drain X/M with a bubble.
            // Hazard inputs are deliberately ignored in this cycle.
            ctrl_mult  = md_kind[1];
            ctrl_div   = md_kind[0];
            xm_we      = 1'b1;
            xm_bubble  = 1'b1;
            mw_we      = 1'b1;
            state_next = MD_WAIT;
          end else if (branch_taken) begin
            {pc_we, fd_we, dx_we, xm_we, mw_we} = '1;
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
          end else if (load_use) begin
            dx_we     = 1'b1;
            dx_bubble = 1'b1;
            xm_we     = 1'b1;
            mw_we     = 1'b1;
          end else begin
            {pc_we, fd_we, dx_we, xm_we, mw_we} = '1;
          end
        end
        MD_WAIT: begin
          md_busy = 1'b1;
          wd_en   = 1'b1;
          if (md_rdy || md_exc || wd_expired) begin
            // Release in the same cycle: the result is written into X/M.
            {pc_we, fd_we, dx_we, xm_we, mw_we} = '1;
            set_timeout = !(md_rdy || md_exc);
            state_next  = RUN;
          end else begin
            xm_we     = 1'b1;
            xm_bubble = 1'b1;
            mw_we     = 1'b1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_timeout_reg <= 1'b0;
    end else if (set_timeout) begin
      md_timeout_reg <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count_reg <= '0;
    end else if (!pc_we && (stall_count_reg != 32'hFFFF_FFFF)) begin
      stall_count_reg <= stall_count_reg + 32'd1;
    end
  end

  assign md_timeout  = md_timeout_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_pipeline_interlock.sv
// Directed bench for pipeline_interlock: load-use, mul with delayed ready,
// branch+load-use, div watchdog timeout, reset mid-wait, back-to-back ops.
module tb_pipeline_interlock;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_use, branch_taken, md_rdy, md_exc;
  logic [31:0] dx_insn;
  logic        pc_we, fd_we, dx_we, xm_we, mw_we;
  logic        fd_flush, dx_bubble, xm_bubble;
  logic        ctrl_mult, ctrl_div, md_busy, md_timeout;
  logic [31:0] stall_count;

  int compared   = 0;
  int mismatched = 0;

  // {opcode, rd/rs/rt/shamt (20 bits), alu_op, 2'b00}
  localparam logic [31:0] INSN_ADD = {5'b00000, 20'h12345, 5'b00000, 2'b00};
  localparam logic [31:0] INSN_MUL = {5'b00000, 20'h0A0B0, 5'b00110, 2'b00};
  localparam logic [31:0] INSN_DIV = {5'b00000, 20'h0C0D0, 5'b00111, 2'b00};

  pipeline_interlock #(.MD_TIMEOUT(64)) dut (
    .clock        (clock),
    .reset        (reset),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .dx_insn      (dx_insn),
    .md_rdy       (md_rdy),
    .md_exc       (md_exc),
    .pc_we        (pc_we),
    .fd_we        (fd_we),
    .dx_we        (dx_we),
    .xm_we        (xm_we),
    .mw_we        (mw_we),
    .fd_flush     (fd_flush),
    .dx_bubble    (dx_bubble),
    .xm_bubble    (xm_bubble),
    .ctrl_mult    (ctrl_mult),
    .ctrl_div     (ctrl_div),
    .md_busy      (md_busy),
    .md_timeout   (md_timeout),
    .stall_count  (stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit
  // after that, well clear of both clock edges.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] en5();
    return {27'd0, pc_we, fd_we, dx_we, xm_we, mw_we};
  endfunction
  function automatic logic [31:0] bub3();
    return {29'd0, fd_flush, dx_bubble, xm_bubble};
  endfunction
  function automatic logic [31:0] ctl2();
    return {30'd0, ctrl_mult, ctrl_div};
  endfunction

  initial begin
    reset = 1'b1; load_use = 1'b0; branch_taken = 1'b0;
    md_rdy = 1'b0; md_exc = 1'b0; dx_insn = INSN_MUL;
    #1;
    // Reset state: a mul in D/X must not launch while reset is held.
    chk("rst_en", en5(), 32'h00);
    chk("rst_bub", bub3(), 32'h0);
    chk("rst_ctl", ctl2(), 32'h0);
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_stall", stall_count, 32'd0);
    chk("rst_tmo", {31'd0, md_timeout}, 32'd0);
    $display("step reset held");
    dx_insn = INSN_ADD;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("run_en", en5(), 32'h1F);
    chk("run_bub", bub3(), 32'h0);
    $display("step plain add");
    tick();
    chk("run_stall", stall_count, 32'd0);

    // Load-use stall
    load_use = 1'b1; #1;
    chk("lu_en", en5(), 32'h07);
    chk("lu_bub", bub3(), 32'h2);
    $display("step load-use");
    tick();
    load_use = 1'b0;
    chk("lu_stall", stall_count, 32'd1);

    // Mul launch, with hazards that must be ignored
    dx_insn = INSN_MUL; load_use = 1'b1; branch_taken = 1'b1; #1;
    chk("mul_ctl", ctl2(), 32'h2);
    chk("mul_en", en5(), 32'h03);
    chk("mul_bub", bub3(), 32'h1);
    chk("mul_busy0", {31'd0, md_busy}, 32'd0);
    $display("step mul launch");
    tick();
    load_use = 1'b0; branch_taken = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      #1;
      chk("mulw_busy", {31'd0, md_busy}, 32'd1);
      chk("mulw_en", en5(), 32'h03);
      chk("mulw_ctl", ctl2(), 32'h0);
      tick();
    end
    md_rdy = 1'b1; #1;
    chk("mulr_en", en5(), 32'h1F);
    chk("mulr_bub", bub3(), 32'h0);
    chk("mulr_busy", {31'd0, md_busy}, 32'd1);
    $display("step mul release");
    tick();
    md_rdy = 1'b0; dx_insn = INSN_ADD; #1;
    chk("mul_busy_end", {31'd0, md_busy}, 32'd0);
    chk("mul_stall", stall_count, 32'd34);

    // md_rdy in RUN is ignored
    md_rdy = 1'b1; #1;
    chk("rdy_run_en", en5(), 32'h1F);
    tick();
    md_rdy = 1'b0; #1;
    chk("rdy_run_busy", {31'd0, md_busy}, 32'd0);
    $display("step stray md_rdy");

    // Branch wins over load-use
    branch_taken = 1'b1; load_use = 1'b1; #1;
    chk("br_en", en5(), 32'h1F);
    chk("br_bub", bub3(), 32'h6);
    $display("step branch+load-use");
    tick();
    branch_taken = 1'b0; load_use = 1'b0;
    chk("br_stall", stall_count, 32'd34);

    // Div with no ready: watchdog release after 64 waiting cycles
    dx_insn = INSN_DIV; #1;
    chk("div_ctl", ctl2(), 32'h1);
    $display("step div launch");
    tick();
    for (int k = 1; k <= 63; k++) begin
      #1;
      chk("divw_en", en5(), 32'h03);
      chk("divw_tmo", {31'd0, md_timeout}, 32'd0);
      tick();
    end
    #1;
    chk("divt_en", en5(), 32'h1F);
    chk("divt_busy", {31'd0, md_busy}, 32'd1);
    tick();
    dx_insn = INSN_ADD; #1;
    chk("divt_tmo", {31'd0, md_timeout}, 32'd1);
    chk("divt_busy_end", {31'd0, md_busy}, 32'd0);
    chk("divt_stall", stall_count, 32'd98);
    $display("step div timeout");
    tick(); tick();
    chk("tmo_sticky", {31'd0, md_timeout}, 32'd1);

    // Reset during MD_WAIT
    dx_insn = INSN_DIV;
    tick();
    repeat (9) tick();
    #1;
    chk("rw_busy_pre", {31'd0, md_busy}, 32'd1);
    #1 reset = 1'b1; #1;
    chk("rw_en", en5(), 32'h00);
    chk("rw_bub", bub3(), 32'h0);
    chk("rw_ctl", ctl2(), 32'h0);
    chk("rw_busy", {31'd0, md_busy}, 32'd0);
    chk("rw_stall", stall_count, 32'd0);
    chk("rw_tmo", {31'd0, md_timeout}, 32'd0);
    $display("step reset mid-wait");
    tick();
    chk("rw_ctl_held", ctl2(), 32'h0);
    reset = 1'b0; #1;
    chk("rw_relaunch", ctl2(), 32'h1);
    tick();
    chk("rw_stall1", stall_count, 32'd1);
    chk("rw_busy2", {31'd0, md_busy}, 32'd1);
    md_exc = 1'b1; #1;
    chk("exc_en", en5(), 32'h1F);
    $display("step exception release");
    tick();
    md_exc = 1'b0;

    // Back-to-back mul then div
    dx_insn = INSN_MUL; #1;
    chk("bb_mul", ctl2(), 32'h2);
    tick();
    md_rdy = 1'b1; #1;
    chk("bb_rel", en5(), 32'h1F);
    tick();
    md_rdy = 1'b0; dx_insn = INSN_DIV; #1;
    chk("bb_div", ctl2(), 32'h1);
    $display("step back-to-back");
    tick();
    chk("bb_busy", {31'd0, md_busy}, 32'd1);
    chk("bb_ctl_off", ctl2(), 32'h0);
    md_rdy = 1'b1;
    tick();
    md_rdy = 1'b0; dx_insn = INSN_ADD; #1;
    chk("bb_done", {31'd0, md_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
